// File: rtl/sam_video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sam_video_pkg
// Description : Shared constants and the colour-expansion helper for the
//               SAM Coupe video output stage.
// Revision    : 1.0 - initial release
// ============================================================================
package sam_video_pkg;

    // Run-time output modes
    localparam logic MODE_PAL = 1'b0;   // 15 kHz passthrough, composite sync
    localparam logic MODE_VGA = 1'b1;   // 31 kHz scandoubled

    // A pixel is three DAC channels packed {r, g, b}
    localparam int PIX_CHANNELS = 3;

    // Widest channel the expansion helper handles
    localparam int MAX_CH_BITS = 16;

    // Packed pixel width for a given DAC channel width (3*OUT_BITS)
    function automatic int pix_width(input int out_bits);
        return PIX_CHANNELS * out_bits;
    endfunction

    // {value, bright repeated (out_bits-in_bits) times}; bright vanishes when
    // the widths are equal because the fill mask is then empty.
    function automatic logic [MAX_CH_BITS-1:0] expand_channel(
        input logic [MAX_CH_BITS-1:0] value,
        input logic                   bright,
        input int                     in_bits,
        input int                     out_bits
    );
        logic [MAX_CH_BITS-1:0] fill;
        fill = bright ? MAX_CH_BITS'((1 << (out_bits - in_bits)) - 1) : '0;
        return (value << (out_bits - in_bits)) | fill;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sam_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sam_line_buffer
// Description : Simple dual-port RAM holding both ping-pong line banks.
//               Synchronous write, registered read (block-RAM friendly).
// Revision    : 1.0 - initial release
// ============================================================================
module sam_line_buffer #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 9
) (
    input  logic              clk24,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [0:(1 << ADDR_W)-1];
    logic [DATA_W-1:0] r_rd_data;

    // Write port plus one-cycle registered read port; no reset on storage
    always_ff @(posedge clk24) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/sam_video_out.sv
`default_nettype none
// ============================================================================
// Module      : sam_video_out
// Description : SAM Coupe video output stage. Expands colour+bright to DAC
//               width and either passes 15 kHz video through or scandoubles
//               it to 31 kHz via a ping-pong line buffer (run-time select).
//               Optional macro SCANLINES_EN: halves the colour of the second
//               doubled line for a CRT scanline look.
// Revision    : 1.0 - initial release
// ============================================================================
module sam_video_out
    import sam_video_pkg::*;
#(
    parameter int IN_BITS    = 2,
    parameter int OUT_BITS   = 3,
    parameter int LINE_DEPTH = 1024,
    parameter int HS_WIDTH   = 64
) (
    input  logic                clk24,
    input  logic                master_reset_n,
    input  logic                ce_pix_in,
    input  logic                ce_pix_out,
    input  logic [IN_BITS-1:0]  r_in,
    input  logic [IN_BITS-1:0]  g_in,
    input  logic [IN_BITS-1:0]  b_in,
    input  logic                bright_in,
    input  logic                hsync_n_in,
    input  logic                vsync_n_in,
    input  logic                scandbl_en,
    output logic [OUT_BITS-1:0] r,
    output logic [OUT_BITS-1:0] g,
    output logic [OUT_BITS-1:0] b,
    output logic                hsync_n,
    output logic                vsync_n,
    output logic                csync,
    output logic                line_ovf
);

    localparam int                 c_pix_w    = pix_width(OUT_BITS);
    localparam int                 c_aw       = $clog2(LINE_DEPTH);
    localparam int                 c_hsc_w    = $clog2(HS_WIDTH + 1);
    localparam logic [c_aw-1:0]    c_addr_max = c_aw'(LINE_DEPTH - 1);
    localparam logic [c_hsc_w-1:0] c_hs_width = c_hsc_w'(HS_WIDTH);

    // Input side state
    logic               r_hs_in_d;
    logic               r_mode;
    logic               r_bank;
    logic [c_aw-1:0]    r_wr_addr;
    logic [c_aw-1:0]    r_line_len;
    logic               r_ovf;

    // Output side state
    logic [c_aw-1:0]    r_rd_addr;
    logic [c_hsc_w-1:0] r_hs_cnt;
    logic               r_blank_d;
    logic [OUT_BITS-1:0] r_r, r_g, r_b;
    logic               r_hs_out, r_vs_out, r_cs_out;

    logic               w_hs_fall;
    logic               w_rd_wrap;
    logic               w_we;
    logic               w_wr_bank;
    logic [c_aw-1:0]    w_wr_addr;
    logic [c_aw:0]      w_ram_wr_addr;
    logic [c_aw:0]      w_ram_rd_addr;
    logic [OUT_BITS-1:0] w_exp_r, w_exp_g, w_exp_b;
    logic [c_pix_w-1:0] w_pix;
    logic [c_pix_w-1:0] w_ram_q;
    logic [c_pix_w-1:0] w_vga_pix;

    assign w_exp_r = OUT_BITS'(expand_channel(MAX_CH_BITS'(r_in), bright_in, IN_BITS, OUT_BITS));
    assign w_exp_g = OUT_BITS'(expand_channel(MAX_CH_BITS'(g_in), bright_in, IN_BITS, OUT_BITS));
    assign w_exp_b = OUT_BITS'(expand_channel(MAX_CH_BITS'(b_in), bright_in, IN_BITS, OUT_BITS));
    assign w_pix   = {w_exp_r, w_exp_g, w_exp_b};

    // Input line start: hsync was high last cycle and is low now
    assign w_hs_fall = r_hs_in_d & ~hsync_n_in;

    // A pixel arriving on the line-start edge lands at address 0 of the new bank
    assign w_wr_bank = w_hs_fall ? ~r_bank : r_bank;
    assign w_wr_addr = w_hs_fall ? '0 : r_wr_addr;
    assign w_we      = ce_pix_in & (w_hs_fall | (r_wr_addr != c_addr_max));

    assign w_ram_wr_addr = {w_wr_bank, w_wr_addr};
    assign w_ram_rd_addr = {~r_bank, r_rd_addr};

    // Reader reached the end of the stored line: restart for the repeat line
    assign w_rd_wrap = ce_pix_out & (r_rd_addr == r_line_len);

    sam_line_buffer #(
        .ADDR_W (c_aw + 1),
        .DATA_W (c_pix_w)
    ) u_line_buffer (
        .clk24     (clk24),
        .i_we      (w_we),
        .i_wr_addr (w_ram_wr_addr),
        .i_wr_data (w_pix),
        .i_rd_addr (w_ram_rd_addr),
        .o_rd_data (w_ram_q)
    );

    // Write side: edge detect, mode latch, bank swap, write pointer, overflow.
    // wr_addr never passes the last address, so latching it is already
    // saturated to LINE_DEPTH-1. The first line in a newly entered doubled
    // mode has no valid stored line, so its length is forced to 0 (black).
    always_ff @(posedge clk24) begin
        if (!master_reset_n) begin
            r_hs_in_d  <= 1'b1;
            r_mode     <= MODE_PAL;
            r_bank     <= 1'b0;
            r_wr_addr  <= '0;
            r_line_len <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_hs_in_d <= hsync_n_in;
            if (w_hs_fall) begin
                r_mode     <= scandbl_en;
                r_bank     <= ~r_bank;
                r_line_len <= (r_mode == MODE_VGA && scandbl_en == MODE_VGA) ? r_wr_addr : '0;
                r_wr_addr  <= ce_pix_in ? c_aw'(1) : '0;
                r_ovf      <= 1'b0;
            end else if (ce_pix_in) begin
                if (r_wr_addr == c_addr_max) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_wr_addr <= r_wr_addr + 1'b1;
                end
            end
        end
    end

    // Read side: address runs 0..line_len twice per input line; every restart
    // opens an HS_WIDTH-tick output sync pulse. Blank flag tracks the RAM latency.
    always_ff @(posedge clk24) begin
        if (!master_reset_n) begin
            r_rd_addr <= '0;
            r_hs_cnt  <= '0;
            r_blank_d <= 1'b0;
        end else begin
            if (w_hs_fall || w_rd_wrap) begin
                r_rd_addr <= '0;
                r_hs_cnt  <= c_hs_width;
            end else if (ce_pix_out) begin
                r_rd_addr <= r_rd_addr + 1'b1;
                if (r_hs_cnt != '0) begin
                    r_hs_cnt <= r_hs_cnt - 1'b1;
                end
            end
            r_blank_d <= (r_hs_cnt != '0);
        end
    end

`ifdef SCANLINES_EN
    logic r_line2;
    logic r_line2_d;

    // Marks the repeated (post-wrap) output line, aligned to RAM latency
    always_ff @(posedge clk24) begin
        if (!master_reset_n) begin
            r_line2   <= 1'b0;
            r_line2_d <= 1'b0;
        end else begin
            if (w_hs_fall) begin
                r_line2 <= 1'b0;
            end else if (w_rd_wrap) begin
                r_line2 <= 1'b1;
            end
            r_line2_d <= r_line2;
        end
    end

    // Doubled pixel: blank in sync, halved on the repeated line
    always_comb begin
        w_vga_pix = w_ram_q;
        if (r_blank_d) begin
            w_vga_pix = '0;
        end else if (r_line2_d) begin
            w_vga_pix = {w_ram_q[c_pix_w-1 -: OUT_BITS] >> 1,
                         w_ram_q[2*OUT_BITS-1 -: OUT_BITS] >> 1,
                         w_ram_q[OUT_BITS-1:0] >> 1};
        end
    end
`else
    // Doubled pixel: blank while the output sync pulse is active
    always_comb begin
        w_vga_pix = w_ram_q;
        if (r_blank_d) begin
            w_vga_pix = '0;
        end
    end
`endif

    // Output registers: doubled stream every clock, or passthrough on ce_pix_in
    always_ff @(posedge clk24) begin
        if (!master_reset_n) begin
            r_r      <= '0;
            r_g      <= '0;
            r_b      <= '0;
            r_hs_out <= 1'b1;
            r_vs_out <= 1'b1;
            r_cs_out <= 1'b1;
        end else if (r_mode == MODE_VGA) begin
            {r_r, r_g, r_b} <= w_vga_pix;
            r_hs_out        <= ~r_blank_d;
            r_vs_out        <= vsync_n_in;
            r_cs_out        <= ~r_blank_d & vsync_n_in;
        end else if (ce_pix_in) begin
            {r_r, r_g, r_b} <= w_pix;
            r_hs_out        <= hsync_n_in;
            r_vs_out        <= vsync_n_in;
            r_cs_out        <= hsync_n_in & vsync_n_in;
        end
    end

    assign r        = r_r;
    assign g        = r_g;
    assign b        = r_b;
    assign hsync_n  = r_hs_out;
    assign vsync_n  = r_vs_out;
    assign csync    = r_cs_out;
    assign line_ovf = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sam_video_out.sv
`default_nettype none
// ============================================================================
// Module      : tb_sam_video_out
// Description : Directed self-checking bench for sam_video_out
//               (IN_BITS=2, OUT_BITS=3, LINE_DEPTH=1024, HS_WIDTH=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sam_video_out;

    logic       clk24 = 1'b0;
    logic       master_reset_n;
    logic       ce_pix_in, ce_pix_out;
    logic [1:0] r_in, g_in, b_in;
    logic       bright_in, hsync_n_in, vsync_n_in, scandbl_en;
    logic [2:0] r, g, b;
    logic       hsync_n, vsync_n, csync, line_ovf;

    int checks   = 0;
    int failures = 0;

`ifdef SCANLINES_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    // Per-clock captures of one input line; index 0 is the hsync fall edge
    logic [8:0] cap_rgb [0:8191];
    logic       cap_hs  [0:8191];
    logic       cap_vs  [0:8191];
    logic       cap_cs  [0:8191];
    logic       cap_ovf [0:8191];

    always #5 clk24 = ~clk24;

    sam_video_out #(
        .IN_BITS    (2),
        .OUT_BITS   (3),
        .LINE_DEPTH (1024),
        .HS_WIDTH   (64)
    ) dut (
        .clk24          (clk24),
        .master_reset_n (master_reset_n),
        .ce_pix_in      (ce_pix_in),
        .ce_pix_out     (ce_pix_out),
        .r_in           (r_in),
        .g_in           (g_in),
        .b_in           (b_in),
        .bright_in      (bright_in),
        .hsync_n_in     (hsync_n_in),
        .vsync_n_in     (vsync_n_in),
        .scandbl_en     (scandbl_en),
        .r              (r),
        .g              (g),
        .b              (b),
        .hsync_n        (hsync_n),
        .vsync_n        (vsync_n),
        .csync          (csync),
        .line_ovf       (line_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected DAC pixel for source pixel p of the ramp (7 useful bits)
    function automatic logic [8:0] exp_rgb(input int p, input bit second);
        logic [6:0] v;
        logic [2:0] er, eg, eb;
        v  = 7'(p);
        er = {v[6:5], v[0]};
        eg = {v[4:3], v[0]};
        eb = {v[2:1], v[0]};
        if (second && SCAN) begin
            er = er >> 1;
            eg = eg >> 1;
            eb = eb >> 1;
        end
        return {er, eg, eb};
    endfunction

    // One input line: 4 clocks per source pixel, ce_pix_out on clocks 0 and 2,
    // hsync_n_in low for the first 16 pixels.
    task automatic run_line(input int npix, input int sw_at, input logic sw_val);
        logic [6:0] v;
        int         idx;
        for (int p = 0; p < npix; p++) begin
            for (int c = 0; c < 4; c++) begin
                if (p == sw_at && c == 0) scandbl_en = sw_val;
                v          = 7'(p);
                ce_pix_in  = (c == 0);
                ce_pix_out = (c == 0) || (c == 2);
                hsync_n_in = (p < 16) ? 1'b0 : 1'b1;
                r_in       = v[6:5];
                g_in       = v[4:3];
                b_in       = v[2:1];
                bright_in  = v[0];
                @(posedge clk24);
                #1;
                idx          = 4 * p + c;
                cap_rgb[idx] = {r, g, b};
                cap_hs[idx]  = hsync_n;
                cap_vs[idx]  = vsync_n;
                cap_cs[idx]  = csync;
                cap_ovf[idx] = line_ovf;
            end
        end
        ce_pix_in  = 1'b0;
        ce_pix_out = 1'b0;
    endtask

    initial begin
        master_reset_n = 1'b0;
        ce_pix_in      = 1'b0;
        ce_pix_out     = 1'b0;
        r_in           = '0;
        g_in           = '0;
        b_in           = '0;
        bright_in      = 1'b0;
        hsync_n_in     = 1'b1;
        vsync_n_in     = 1'b1;
        scandbl_en     = 1'b0;
        repeat (2) @(posedge clk24);
        #1;
        check("rst_rgb",   {r, g, b}, 9'd0);
        check("rst_syncs", {hsync_n, vsync_n, csync}, 3'b111);
        check("rst_ovf",   line_ovf, 1'b0);
        master_reset_n = 1'b1;

        // Passthrough: one clock latency from ce_pix_in
        r_in = 2'b10; g_in = 2'b01; b_in = 2'b11; bright_in = 1'b1;
        hsync_n_in = 1'b0; vsync_n_in = 1'b1; ce_pix_in = 1'b1;
        @(posedge clk24); #1;
        check("pt_rgb1",   {r, g, b}, 9'b101_011_111);
        check("pt_sync1",  {hsync_n, vsync_n, csync}, 3'b010);
        r_in = 2'b11; g_in = 2'b00; b_in = 2'b01; bright_in = 1'b0;
        hsync_n_in = 1'b1; vsync_n_in = 1'b0; ce_pix_in = 1'b1;
        @(posedge clk24); #1;
        check("pt_rgb2",   {r, g, b}, 9'b110_000_010);
        check("pt_sync2",  {hsync_n, vsync_n, csync}, 3'b100);
        r_in = 2'b00; vsync_n_in = 1'b1; ce_pix_in = 1'b0;
        @(posedge clk24); #1;
        check("pt_hold",   {r, g, b}, 9'b110_000_010);
        repeat (2) @(posedge clk24);
        #1;

        // Enter doubled mode: first line has no stored line, output is black
        scandbl_en = 1'b1;
        run_line(384, -1, 1'b0);
        check("l1_black_rgb", cap_rgb[200], 9'd0);
        check("l1_black_hs",  cap_hs[200], 1'b0);

        // Ramp doubled; output tick k appears at capture index 2k+2
        run_line(384, -1, 1'b0);
        check("l2_hs_k10",    cap_hs[22], 1'b0);
        check("l2_blank_k10", cap_rgb[22], 9'd0);
        check("l2_hs_k63",    cap_hs[128], 1'b0);
        check("l2_hs_k64",    cap_hs[130], 1'b1);
        check("l2_rgb_k64",   cap_rgb[130], exp_rgb(64, 1'b0));
        check("l2_vscs_k64",  {cap_vs[130], cap_cs[130]}, 2'b11);
        check("l2_rgb_k199",  cap_rgb[400], exp_rgb(199, 1'b0));
        check("l2_hs_rep10",  cap_hs[792], 1'b0);
        check("l2_hs_rep64",  cap_hs[900], 1'b1);
        check("l2_rgb_rep64", cap_rgb[900], exp_rgb(64, 1'b1));
        check("l2_rgb_rep300", cap_rgb[1372], exp_rgb(300, 1'b1));

        // Mode dropped mid-line: still doubling until the next line start
        run_line(384, 100, 1'b0);
        check("l3_rgb_k64",   cap_rgb[130], exp_rgb(64, 1'b0));
        check("l3_hs_rep10",  cap_hs[792], 1'b0);
        check("l3_blank_rep", cap_rgb[792], 9'd0);

        // Now passthrough
        run_line(384, -1, 1'b0);
        check("l4_hs_p1",     cap_hs[4], 1'b0);
        check("l4_cs_p1",     cap_cs[4], 1'b0);
        check("l4_hs_p198",   cap_hs[792], 1'b1);
        check("l4_rgb_p198",  cap_rgb[792], exp_rgb(198, 1'b0));

        // Overflow line in doubled mode
        scandbl_en = 1'b1;
        run_line(1100, -1, 1'b0);
        check("l5_ovf_p1022", cap_ovf[4088], 1'b0);
        check("l5_ovf_p1023", cap_ovf[4092], 1'b1);
        check("l5_ovf_sticky", cap_ovf[4396], 1'b1);

        // Stored length saturated at 1023: reader wraps after tick 1023
        run_line(1100, -1, 1'b0);
        check("l6_ovf_clr",   cap_ovf[0], 1'b0);
        check("l6_rgb_k500",  cap_rgb[1002], exp_rgb(500, 1'b0));
        check("l6_hs_k1023",  cap_hs[2048], 1'b1);
        check("l6_hs_k1024",  cap_hs[2050], 1'b0);
        check("l6_ovf_again", cap_ovf[4092], 1'b1);

        // Reset in the middle of activity
        master_reset_n = 1'b0;
        ce_pix_in = 1'b1; ce_pix_out = 1'b1;
        @(posedge clk24); #1;
        check("mid_rst_rgb",   {r, g, b}, 9'd0);
        check("mid_rst_syncs", {hsync_n, vsync_n, csync}, 3'b111);
        check("mid_rst_ovf",   line_ovf, 1'b0);

        // Mode latch returned to passthrough despite scandbl_en=1
        master_reset_n = 1'b1;
        r_in = 2'b01; g_in = 2'b00; b_in = 2'b00; bright_in = 1'b1;
        hsync_n_in = 1'b1; ce_pix_in = 1'b1; ce_pix_out = 1'b0;
        @(posedge clk24); #1;
        check("post_rst_pt",   {r, g, b}, 9'b011_001_001);
        ce_pix_in = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sam_video_out.md
Name: sam_video_out

Overview:
- Parametrised video output stage for the SAM Coupé core; it sits between the machine's RGB/bright/sync outputs and the board's DAC pins.
- Expands IN_BITS-per-channel colour plus the bright bit to an OUT_BITS-wide DAC value.
- Two modes: 15 kHz passthrough with composite sync, or a 31 kHz scandoubler built on a ping-pong line buffer.
- Mode is selectable at run time, so one bitstream drives either a PAL TV or a VGA monitor.

Parameters:
IN_BITS, 2, colour bits per channel from the machine (excluding bright)
OUT_BITS, 3, DAC bits per channel; must be >= IN_BITS
LINE_DEPTH, 1024, pixels per line buffer bank (power of two)
HS_WIDTH, 64, output hsync pulse width in doubled-rate ticks (ce_pix_out)

Ports:
clk24  in  1  single system clock
master_reset_n  in  1  synchronous active-low reset
ce_pix_in  in  1  input pixel enable (one pulse per source pixel)
ce_pix_out  in  1  output pixel enable, exactly twice the ce_pix_in rate
r_in, g_in, b_in  in  IN_BITS each  source colour
bright_in  in  1  source bright bit
hsync_n_in, vsync_n_in  in  1 each  source syncs, active low
scandbl_en  in  1  0 = 15 kHz passthrough, 1 = 31 kHz doubled
r, g, b  out  OUT_BITS each  DAC colour
hsync_n, vsync_n, csync  out  1 each  output syncs, active low
line_ovf  out  1  sticky: current input line exceeded LINE_DEPTH

Behaviour:
Interface rules:
- Clock is clk24; reset is master_reset_n, synchronous, active-low. These are fixed.

Reset:
- r/g/b = 0; hsync_n = vsync_n = csync = 1; line_ovf = 0.
- All counters 0, write bank 0, active mode latched = 0.
- Reset asserted mid-line applies these on the next edge and discards the buffer contents.

Colour expansion (combinational, then registered):
- Output per channel = {in, bright replicated (OUT_BITS-IN_BITS) times}.
- When OUT_BITS == IN_BITS, bright is ignored.

Mode latch:
- scandbl_en is sampled only on a registered falling edge of hsync_n_in.
- Changes mid-line take effect at the next input line start.

Passthrough (mode 0):
- On ce_pix_in, register expanded colour, hsync_n_in and vsync_n_in.
- Latency is 1 clk24 from ce_pix_in.
- csync = hsync_n & vsync_n, registered in the same cycle.

Scandouble (mode 1), write side:
- hsync fall edge is detected from a 1-cycle delayed copy of hsync_n_in.
- On the fall edge:
  - Toggle the write bank.
  - Latch line_len = wr_addr, saturated to LINE_DEPTH-1.
  - Clear wr_addr and line_ovf.
- A ce_pix_in coinciding with the edge is written to address 0 of the new bank.
- On each ce_pix_in, write the expanded pixel to {bank, wr_addr}, then wr_addr++.
- At wr_addr == LINE_DEPTH-1 further writes are dropped, wr_addr holds, and line_ovf is set.

Scandouble (mode 1), read side:
- Reads from the bank not being written, advancing on ce_pix_out.
- rd_addr runs 0..line_len, then wraps to 0 (second output line).
- rd_addr is also forced to 0 on an input hsync fall edge.
- Each rd_addr reset to 0 starts an hsync_n low pulse of HS_WIDTH ce_pix_out ticks.
- Buffer read latency is 1 clk24; colour and hsync are aligned after that cycle.
- If rd_addr falls inside the hsync pulse, the colour output is 0 (blanking).
- vsync_n = vsync_n_in registered.
- csync = hsync_n & vsync_n.

Boundary:
- First line after reset or a mode change: line_len = 0 until the first hsync edge, so the output is black.
- line_len = 0 gives a rd_addr that wraps every tick.

Optional Feature:
SCANLINES_EN
- Defined: on the second (post-wrap) doubled line, each output channel is logically shifted right by 1, giving a CRT scanline effect.
- Undefined: both doubled lines are identical; no extra logic.
- Passthrough mode is unaffected either way.

Decomposition:
- Package sam_video_pkg holds:
  - the mode localparams (MODE_PAL=0, MODE_VGA=1);
  - the colour-expansion function;
  - a pixel struct-equivalent width constant (3*OUT_BITS).
- One sub-module: sam_line_buffer, a simple dual-port RAM of 2*LINE_DEPTH x 3*OUT_BITS, synchronous write, registered read (infers block RAM).

Test Plan:
- Reset mid-line: hold master_reset_n=0 for 1 cycle -> next cycle rgb=0, all syncs=1, line_ovf=0.
- Mode 0, IN=2/OUT=3: r_in=2'b10, bright=1, ce_pix_in -> r=3'b101 one clk24 later; hsync_n_in=0, vsync_n_in=1 -> csync=0.
- Mode 1, 384-pixel line, ramp pattern:
  - Following line outputs the ramp 0..383 twice.
  - hsync_n low for 64 ce_pix_out ticks at each restart.
  - Colour is 0 during hsync.
- Overflow: 1100 ce_pix_in in one line, LINE_DEPTH=1024 -> line_ovf=1 after pixel 1023, line_len=1023, cleared at next hsync fall.
- Mode switch: toggle scandbl_en mid-line -> output behaviour unchanged until the next hsync_n_in fall edge, then switches.
- SCANLINES_EN defined, pixel 3'b110 -> first doubled line 3'b110, second 3'b011.
